// File: rtl/rsa_job_sched_if.sv
// Request/response bus between two requesters and the rsa4k job scheduler.
// Slice i of every 2-bit or 2*WIDTH signal belongs to requester i.
interface rsa_job_sched_if #(
    parameter int WIDTH = 4096
);
    // A transfer happens on a rising clk edge where valid[i] and ready[i] are both high;
    // valid may not depend on ready, and the data qualified by valid is held until that edge.
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_message;
    logic [2*WIDTH-1:0] req_exponent;
    logic [2*WIDTH-1:0] req_modulus;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_message, req_exponent, req_modulus, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_message, req_exponent, req_modulus, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rsa_job_sched.sv
// Shares one rsa4k core between two requesters: round-robin grant, core re-reset per job.
// Optional RSA_SCHED_TIMEOUT_EN: abort a job after TIMEOUT_CYCLES RUN cycles with rsp_err set.
module rsa_job_sched #(
    parameter int WIDTH          = 4096,
    parameter int CLR_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic               clk,
    input  logic               reset,
    rsa_job_sched_if.slave     bus,
    output logic               busy,
    output logic               core_reset,
    output logic               core_go,
    output logic [WIDTH-1:0]   core_message,
    output logic [WIDTH-1:0]   core_exponent,
    output logic [WIDTH-1:0]   core_modulus,
    input  logic [WIDTH-1:0]   core_cypher,
    input  logic               core_done,
    output logic [2:0]         dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    state_t           state;
    state_t           state_next;
    logic [CLR_W-1:0] clr_cnt;
    logic             id;
    logic             rr_last;
    logic             run_first;
    logic [WIDTH-1:0] result;
    logic             grant_id;
    logic [1:0]       grant;
    logic             accept;
    logic             done_hit;
    logic             timeout_hit;

    // With both requesters pending, the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~rr_last;
            default: grant_id = 1'b0;
        endcase
    end

    assign grant = (state == IDLE && !reset && bus.req_valid != 2'b00)
                   ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept        = |(grant & bus.req_valid);
    assign done_hit      = (state == RUN) && !run_first && core_done;
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = result;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

`ifdef RSA_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] run_cnt;
    logic            err;

    assign timeout_hit = (state == RUN) && !done_hit && (run_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign bus.rsp_err = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == LOAD) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end else if (state == RESP && bus.rsp_ready[id]) begin
                err <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CLR;
            CLR:     if (clr_cnt == CLR_W'(1)) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (done_hit || timeout_hit) state_next = RESP;
            RESP:    if (bus.rsp_ready[id]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            core_reset    <= 1'b1;
            core_go       <= 1'b0;
            core_message  <= '0;
            core_exponent <= '0;
            core_modulus  <= '0;
            result        <= '0;
            id            <= 1'b0;
            rr_last       <= 1'b1;
            run_first     <= 1'b0;
            clr_cnt       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    core_reset <= accept;
                    if (accept) begin
                        core_message  <= grant_id ? bus.req_message[2*WIDTH-1:WIDTH]
                                                  : bus.req_message[WIDTH-1:0];
                        core_exponent <= grant_id ? bus.req_exponent[2*WIDTH-1:WIDTH]
                                                  : bus.req_exponent[WIDTH-1:0];
                        core_modulus  <= grant_id ? bus.req_modulus[2*WIDTH-1:WIDTH]
                                                  : bus.req_modulus[WIDTH-1:0];
                        id            <= grant_id;
                        rr_last       <= grant_id;
                        clr_cnt       <= CLR_W'(CLR_CYCLES);
                    end
                end
                CLR: begin
                    if (clr_cnt == CLR_W'(1)) begin
                        core_reset <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    core_go   <= 1'b1;
                    run_first <= 1'b1;
                end
                RUN: begin
                    // done may still be stale on the first RUN cycle after the core reset.
                    run_first <= 1'b0;
                    if (done_hit) begin
                        result  <= core_cypher;
                        core_go <= 1'b0;
                    end else if (timeout_hit) begin
                        result     <= '0;
                        core_go    <= 1'b0;
                        core_reset <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[id]) core_reset <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_job_sched.sv
// Directed bench for rsa_job_sched with a small behavioural modexp core in place of rsa4k.
module tb_rsa_job_sched;
    localparam int W   = 16;
    localparam int CLR = 4;
    localparam int TO  = 16;
    localparam int LAT = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           busy;
    logic           core_reset;
    logic           core_go;
    logic [W-1:0]   core_message;
    logic [W-1:0]   core_exponent;
    logic [W-1:0]   core_modulus;
    logic [W-1:0]   core_cypher;
    logic           core_done;
    logic [2:0]     dbg_state;
    int             tests = 0;
    int             fails = 0;
    int             cyc = 0;

    rsa_job_sched_if #(.WIDTH(W)) bus ();

    rsa_job_sched #(
        .WIDTH(W),
        .CLR_CYCLES(CLR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy),
        .core_reset(core_reset),
        .core_go(core_go),
        .core_message(core_message),
        .core_exponent(core_exponent),
        .core_modulus(core_modulus),
        .core_cypher(core_cypher),
        .core_done(core_done),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    // behavioural core: level done LAT+1 cycles after go, cleared by core_reset
    logic         stub = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_cypher = '0;
    int           m_cnt = 0;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        longint r;
        longint x;
        r = 1;
        x = longint'(b) % longint'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % longint'(m);
            x = (x * x) % longint'(m);
        end
        return W'(r);
    endfunction

    assign core_done   = m_done & ~stub;
    assign core_cypher = m_cypher;

    always @(posedge clk) begin
        if (core_reset) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (core_go && !m_done) begin
            if (m_cnt == LAT) begin
                m_done   <= 1'b1;
                m_cypher <= modexp(core_message, core_exponent, core_modulus);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: present a job on the masked requesters and wait for the grant
    task automatic send(input logic [1:0] mask, input int msg, input int e, input int m,
                        input int owner, input bit keep, output int t_acc);
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            if (mask[i]) begin
                bus.req_message[i*W +: W]  = W'(msg);
                bus.req_exponent[i*W +: W] = W'(e);
                bus.req_modulus[i*W +: W]  = W'(m);
            end
        end
        bus.req_valid = bus.req_valid | mask;
        #1;
        while (bus.req_ready == 2'b00 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        t_acc = cyc;
        check("grant_wait", 32'(n < 300), 1);
        check("grant", bus.req_ready, (owner != 0) ? 2'b10 : 2'b01);
        @(negedge clk);
        if (!keep) begin
            bus.req_valid[owner] = 1'b0;
            bus.req_message[owner*W +: W]  = W'($urandom_range(0, 65535));
            bus.req_exponent[owner*W +: W] = W'($urandom_range(0, 65535));
            bus.req_modulus[owner*W +: W]  = W'($urandom_range(1, 65535));
        end
    endtask

    // driver/monitor: follow the job to its response, optionally stall, then take it
    task automatic collect(input int owner, input int exp_data, input bit exp_err,
                           input int t_acc, input int hold, output int t_rsp, output int go_c);
        int n = 0;
        int rst_cnt = 0;
        bit quiet = 1'b1;
        bit stable = 1'b1;
        logic [1:0] own;
        own  = (owner != 0) ? 2'b10 : 2'b01;
        go_c = -1;
        while (bus.rsp_valid == 2'b00 && n < 400) begin
            if (core_reset) rst_cnt++;
            if (core_go && go_c < 0) go_c = cyc;
            if (bus.req_ready != 2'b00) quiet = 1'b0;
            @(negedge clk);
            n++;
        end
        t_rsp = cyc;
        check("rsp_wait", 32'(n < 400), 1);
        check("rsp_owner", bus.rsp_valid, own);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err", bus.rsp_err, exp_err);
        check("clr_cycles", rst_cnt, CLR);
        check("go_latency", go_c - t_acc, CLR + 2);
        check("ready_low_in_job", quiet, 1);
        if (exp_err) check("reset_held_resp", core_reset, 1);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (bus.rsp_valid !== own || bus.rsp_data !== W'(exp_data) ||
                    bus.req_ready !== 2'b00) stable = 1'b0;
            end
            check("hold_stable", stable, 1);
        end
        bus.rsp_ready[1 - owner] = 1'b1;
        @(negedge clk);
        check("foreign_ready_ignored", bus.rsp_valid, own);
        bus.rsp_ready[1 - owner] = 1'b0;
        bus.rsp_ready[owner] = 1'b1;
        @(negedge clk);
        bus.rsp_ready[owner] = 1'b0;
        check("rsp_dropped", bus.rsp_valid, 0);
    endtask

    initial begin
        int t;
        int tr;
        int tg;
        int th;
        int n;
        bit stray;
        bus.req_valid    = 2'b00;
        bus.rsp_ready    = 2'b00;
        bus.req_message  = '0;
        bus.req_exponent = '0;
        bus.req_modulus  = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_core_go", core_go, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_core_reset_drop", core_reset, 0);

        // single job: 8^13 mod 77 = 50
        send(2'b01, 8, 13, 77, 0, 1'b0, t);
        collect(0, 50, 1'b0, t, 0, tr, tg);

        // round trip on requester 1: 50^37 mod 77 = 8
        send(2'b10, 50, 37, 77, 1, 1'b0, t);
        collect(1, 8, 1'b0, t, 0, tr, tg);

        // another pattern: 2^10 mod 1000 = 24
        send(2'b10, 2, 10, 1000, 1, 1'b0, t);
        collect(1, 24, 1'b0, t, 0, tr, tg);

        // contention after reset: grants alternate starting at 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            send(2'b11, 8, 13, 77, j % 2, 1'b1, t);
            collect(j % 2, 50, 1'b0, t, 0, tr, tg);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);

        // backpressure with requester 1 waiting
        send(2'b01, 8, 13, 77, 0, 1'b0, t);
        bus.req_message[W +: W]  = W'(50);
        bus.req_exponent[W +: W] = W'(37);
        bus.req_modulus[W +: W]  = W'(77);
        bus.req_valid[1] = 1'b1;
        collect(0, 50, 1'b0, t, 20, tr, tg);
        th = cyc;
        send(2'b10, 50, 37, 77, 1, 1'b0, t);
        check("req1_first_idle", t, th);
        collect(1, 8, 1'b0, t, 0, tr, tg);

        // reset while the core is running
        send(2'b01, 8, 13, 77, 0, 1'b0, t);
        n = 0;
        while (!core_go && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reached_run", core_go, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_core_reset", core_reset, 1);
        check("abort_core_go", core_go, 0);
        check("abort_busy", busy, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_core_message", core_message, 0);
        reset = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) stray = 1'b1;
        end
        check("no_rsp_after_abort", stray, 0);
        send(2'b01, 8, 13, 77, 0, 1'b0, t);
        collect(0, 50, 1'b0, t, 0, tr, tg);

`ifdef RSA_SCHED_TIMEOUT_EN
        // core never finishes: error response exactly TO cycles after go
        stub = 1'b1;
        send(2'b01, 8, 13, 77, 0, 1'b0, t);
        collect(0, 0, 1'b1, t, 0, tr, tg);
        check("timeout_latency", tr - tg, TO);
        check("err_cleared", bus.rsp_err, 0);
        stub = 1'b0;
        send(2'b10, 50, 37, 77, 1, 1'b0, t);
        collect(1, 8, 1'b0, t, 0, tr, tg);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
